// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one combinational ALU between two
//               requesters, with a held response channel.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req0_Valid,
    input  logic [OP_W-1:0]   Req0_Op,
    input  logic [DATA_W-1:0] Req0_A,
    input  logic [DATA_W-1:0] Req0_B,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [OP_W-1:0]   Req1_Op,
    input  logic [DATA_W-1:0] Req1_A,
    input  logic [DATA_W-1:0] Req1_B,
    output logic              Req1_Ready,
    output logic [OP_W-1:0]   AluControl,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,
    output logic              Rsp_Valid,
    output logic              Rsp_Id,
    output logic [DATA_W-1:0] Rsp_Result,
    output logic              Rsp_Zero,
    output logic              Rsp_Err,
    input  logic              Rsp_Ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                ptr_q;
    logic                id_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_zero_q;
    logic                rsp_err_q;

    logic                grant_vld;
    logic                grant_id;
    logic                op_legal;
    logic                in_idle;
    logic                in_exec;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_vld = Req0_Valid | Req1_Valid;
        if (Req0_Valid && Req1_Valid) begin
            grant_id = ptr_q;
        end else begin
            grant_id = Req1_Valid;
        end
    end

    assign in_idle  = (state_q == IDLE);
    assign in_exec  = (state_q == EXEC);
    assign op_legal = (op_q <= OP_W'(8)) || (op_q == OP_W'(12));

    assign Req0_Ready = Rst && in_idle && Req0_Valid && !grant_id;
    assign Req1_Ready = Rst && in_idle && Req1_Valid && grant_id;

    assign AluControl = in_exec ? op_q : '0;
    assign AluA       = in_exec ? a_q  : '0;
    assign AluB       = in_exec ? b_q  : '0;

    assign Rsp_Valid  = rsp_valid_q;
    assign Rsp_Id     = rsp_id_q;
    assign Rsp_Result = rsp_result_q;
    assign Rsp_Zero   = rsp_zero_q;
    assign Rsp_Err    = rsp_err_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        id_q    <= grant_id;
                        op_q    <= grant_id ? Req1_Op : Req0_Op;
                        a_q     <= grant_id ? Req1_A  : Req0_A;
                        b_q     <= grant_id ? Req1_B  : Req0_B;
                        ptr_q   <= ~grant_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    // Illegal opcodes never look at the ALU outputs.
                    if (op_legal) begin
                        rsp_result_q <= AluResult;
                        rsp_zero_q   <= AluZero;
                        rsp_err_q    <= 1'b0;
                    end else begin
                        rsp_result_q <= '0;
                        rsp_zero_q   <= 1'b1;
                        rsp_err_q    <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (Rsp_Ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Req0_Valid, Req1_Valid;
    logic [OW-1:0] Req0_Op, Req1_Op;
    logic [DW-1:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic          Req0_Ready, Req1_Ready;
    logic [OW-1:0] AluControl;
    logic [DW-1:0] AluA, AluB, AluResult;
    logic          AluZero;
    logic          Rsp_Valid, Rsp_Id, Rsp_Zero, Rsp_Err, Rsp_Ready;
    logic [DW-1:0] Rsp_Result;

    int checks  = 0;
    int errors  = 0;
    int exp_ptr = 0;

    always #5 Clk = ~Clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0_Valid(Req0_Valid), .Req0_Op(Req0_Op), .Req0_A(Req0_A), .Req0_B(Req0_B),
        .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_Op(Req1_Op), .Req1_A(Req1_A), .Req1_B(Req1_B),
        .Req1_Ready(Req1_Ready),
        .AluControl(AluControl), .AluA(AluA), .AluB(AluB),
        .AluResult(AluResult), .AluZero(AluZero),
        .Rsp_Valid(Rsp_Valid), .Rsp_Id(Rsp_Id), .Rsp_Result(Rsp_Result),
        .Rsp_Zero(Rsp_Zero), .Rsp_Err(Rsp_Err), .Rsp_Ready(Rsp_Ready)
    );

    // Shared ALU; illegal opcodes deliberately produce non-zero garbage.
    function automatic logic [DW-1:0] alu_env(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h4:    return a << b[4:0];
            4'h5:    return a >> b[4:0];
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            4'h8:    return $unsigned($signed(a) >>> b[4:0]);
            4'hC:    return ~(a | b);
            default: return a ^ b ^ 32'hDEAD_0001;
        endcase
    endfunction

    function automatic logic op_legal(input logic [OW-1:0] op);
        return (op <= 4'h8) || (op == 4'hC);
    endfunction

    function automatic logic [DW-1:0] exp_result(input logic [OW-1:0] op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        return op_legal(op) ? alu_env(op, a, b) : '0;
    endfunction

    assign AluResult = alu_env(AluControl, AluA, AluB);
    assign AluZero   = (AluResult == '0);

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        Rsp_Ready = 1'b0;
        cyc();
        cyc();
        Rst = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        Req0_Valid = 1'b1; Req1_Valid = 1'b1; Rsp_Ready = 1'b1;
        Req0_Op = 4'h2; Req0_A = 32'd3; Req0_B = 32'd4;
        Req1_Op = 4'h1; Req1_A = 32'd8; Req1_B = 32'd1;
        cyc(); cyc(); #1;
        checks++;
        if ({Req0_Ready, Req1_Ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {Req0_Ready, Req1_Ready});
        end
        checks++;
        if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err} !== '0) begin
            errors++; $display("FAIL reset_rsp: got v%b id%b r%h z%b e%b expected all 0",
                               Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err);
        end
        checks++;
        if ({AluControl, AluA, AluB} !== '0) begin
            errors++; $display("FAIL reset_alu: got %h %h %h expected 0", AluControl, AluA, AluB);
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        Rst = 1'b1;
        exp_ptr = 0;
        cyc(); #1;
        checks++;
        if ({Req0_Ready, Req1_Ready, Rsp_Valid} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle: got %b expected 000", {Req0_Ready, Req1_Ready, Rsp_Valid});
        end
    endtask

    task automatic test_single_op();
        Req0_Valid = 1'b1; Req0_Op = 4'h2; Req0_A = 32'd5; Req0_B = 32'd7; Rsp_Ready = 1'b1;
        #1;
        checks++;
        if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
            errors++; $display("FAIL single_grant: got %b expected 10", {Req0_Ready, Req1_Ready});
        end
        exp_ptr = 1;
        cyc(); Req0_Valid = 1'b0; #1;
        checks++;
        if ({Rsp_Valid, Req0_Ready, AluControl, AluA, AluB} !== {1'b0, 1'b0, 4'h2, 32'd5, 32'd7}) begin
            errors++; $display("FAIL single_exec: got v%b rdy%b alu %h %h %h expected v0 rdy0 alu 2 5 7",
                               Rsp_Valid, Req0_Ready, AluControl, AluA, AluB);
        end
        cyc(); #1;
        checks++;
        if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err} !== {1'b1, 1'b0, 32'd12, 1'b0, 1'b0}) begin
            errors++; $display("FAIL single_rsp: got v%b id%b r%0d z%b e%b expected v1 id0 r12 z0 e0",
                               Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err);
        end
        cyc(); #1;
        checks++;
        if (Rsp_Valid !== 1'b0) begin
            errors++; $display("FAIL single_release: got Rsp_Valid %b expected 0", Rsp_Valid);
        end
    endtask

    task automatic test_contention();
        logic g;
        logic [OW-1:0] eop;
        logic [DW-1:0] ea, eb, er;
        do_reset();
        Req0_Op = 4'h6; Req0_A = 32'd9;    Req0_B = 32'd9;
        Req1_Op = 4'h0; Req1_A = 32'hF0;   Req1_B = 32'h0F;
        Rsp_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Req0_Valid = 1'b1; Req1_Valid = 1'b1;
            #1;
            g = (i % 2 == 1);
            checks++;
            if ({Req0_Ready, Req1_Ready} !== {~g, g}) begin
                errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, {Req0_Ready, Req1_Ready}, {~g, g});
            end
            exp_ptr = g ? 0 : 1;
            eop = g ? Req1_Op : Req0_Op;
            ea  = g ? Req1_A  : Req0_A;
            eb  = g ? Req1_B  : Req0_B;
            er  = exp_result(eop, ea, eb);
            cyc(); #1;
            checks++;
            if ({Req0_Ready, Req1_Ready, AluControl} !== {2'b00, eop}) begin
                errors++; $display("FAIL contention_exec[%0d]: got rdy %b op %h expected rdy 00 op %h",
                                   i, {Req0_Ready, Req1_Ready}, AluControl, eop);
            end
            cyc(); #1;
            checks++;
            if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err} !== {1'b1, g, er, (er == '0), 1'b0}) begin
                errors++; $display("FAIL contention_rsp[%0d]: got v%b id%b r%h z%b e%b expected v1 id%b r%h z%b e0",
                                   i, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err, g, er, (er == '0));
            end
            cyc();
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] er;
        Req1_Valid = 1'b1; Req1_Op = 4'h2;
        Req1_A = $urandom; Req1_B = $urandom;
        er = exp_result(Req1_Op, Req1_A, Req1_B);
        Rsp_Ready = 1'b0;
        #1;
        checks++;
        if ({Req0_Ready, Req1_Ready} !== 2'b01) begin
            errors++; $display("FAIL bp_grant: got %b expected 01", {Req0_Ready, Req1_Ready});
        end
        exp_ptr = 0;
        cyc();
        Req0_Valid = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err}
                    !== {2'b00, 1'b1, 1'b1, er, (er == '0), 1'b0}) begin
                errors++; $display("FAIL bp_hold[%0d]: got rdy %b v%b id%b r%h z%b e%b expected rdy 00 v1 id1 r%h z%b e0",
                                   k, {Req0_Ready, Req1_Ready}, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err,
                                   er, (er == '0));
            end
            cyc();
        end
        Rsp_Ready = 1'b1;
        cyc(); #1;
        checks++;
        if ({Rsp_Valid, Req0_Ready, Req1_Ready} !== 3'b010) begin
            errors++; $display("FAIL bp_release: got v%b rdy %b expected v0 rdy 10",
                               Rsp_Valid, {Req0_Ready, Req1_Ready});
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        cyc();
    endtask

    task automatic test_illegal();
        Req1_Valid = 1'b1; Req1_Op = 4'hF; Req1_A = $urandom; Req1_B = $urandom;
        Rsp_Ready = 1'b1;
        #1;
        checks++;
        if ({Req0_Ready, Req1_Ready} !== 2'b01) begin
            errors++; $display("FAIL illegal_grant: got %b expected 01", {Req0_Ready, Req1_Ready});
        end
        exp_ptr = 0;
        cyc(); Req1_Valid = 1'b0;
        cyc(); #1;
        checks++;
        if ({Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err} !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL illegal_rsp: got v%b id%b r%h z%b e%b expected v1 id1 r0 z1 e1",
                               Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err);
        end
        cyc();
    endtask

    task automatic test_reset_mid_op();
        Req0_Valid = 1'b1; Req0_Op = 4'h3; Req0_A = $urandom; Req0_B = $urandom;
        Rsp_Ready = 1'b0;
        cyc();
        Req1_Valid = 1'b1;
        Rst = 1'b0;
        #1;
        checks++;
        if ({Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err, AluControl, AluA, AluB} !== '0) begin
            errors++; $display("FAIL midop_reset: got rdy %b v%b alu %h %h %h expected all 0",
                               {Req0_Ready, Req1_Ready}, Rsp_Valid, AluControl, AluA, AluB);
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0; Rsp_Ready = 1'b1;
        cyc();
        Rst = 1'b1;
        exp_ptr = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (Rsp_Valid !== 1'b0) begin
                errors++; $display("FAIL midop_no_rsp[%0d]: got Rsp_Valid %b expected 0", k, Rsp_Valid);
            end
            cyc();
        end
        Req0_Valid = 1'b1; Req1_Valid = 1'b1;
        #1;
        checks++;
        if ({Req0_Ready, Req1_Ready} !== 2'b10) begin
            errors++; $display("FAIL midop_ptr: got %b expected 10", {Req0_Ready, Req1_Ready});
        end
        Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        int pat, gaps, stall;
        logic g;
        logic [OW-1:0] eop;
        logic [DW-1:0] ea, eb, er;
        for (int t = 0; t < 40; t++) begin
            gaps = $urandom_range(0, 2);
            for (int k = 0; k < gaps; k++) begin
                Req0_Valid = 1'b0; Req1_Valid = 1'b0; Rsp_Ready = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({Req0_Ready, Req1_Ready, Rsp_Valid} !== 3'b000) begin
                    errors++; $display("FAIL rnd_gap[%0d]: got %b expected 000", t, {Req0_Ready, Req1_Ready, Rsp_Valid});
                end
                cyc();
            end
            pat = $urandom_range(1, 3);
            Req0_Valid = (pat & 1) != 0; Req1_Valid = (pat & 2) != 0;
            Req0_Op = 4'($urandom_range(0, 15)); Req0_A = $urandom; Req0_B = $urandom;
            Req1_Op = 4'($urandom_range(0, 15)); Req1_A = $urandom; Req1_B = $urandom;
            Rsp_Ready = 1'($urandom_range(0, 1));
            #1;
            g = (Req0_Valid && Req1_Valid) ? (exp_ptr == 1) : Req1_Valid;
            checks++;
            if ({Req0_Ready, Req1_Ready, Rsp_Valid} !== {~g, g, 1'b0}) begin
                errors++; $display("FAIL rnd_grant[%0d]: got %b expected %b", t,
                                   {Req0_Ready, Req1_Ready, Rsp_Valid}, {~g, g, 1'b0});
            end
            exp_ptr = g ? 0 : 1;
            eop = g ? Req1_Op : Req0_Op;
            ea  = g ? Req1_A  : Req0_A;
            eb  = g ? Req1_B  : Req0_B;
            er  = exp_result(eop, ea, eb);
            cyc();
            Req0_Valid = 1'($urandom_range(0, 1)); Req1_Valid = 1'($urandom_range(0, 1));
            Rsp_Ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({Req0_Ready, Req1_Ready, Rsp_Valid, AluControl, AluA, AluB} !== {3'b000, eop, ea, eb}) begin
                errors++; $display("FAIL rnd_exec[%0d]: got rdy %b v%b alu %h %h %h expected rdy 00 v0 alu %h %h %h",
                                   t, {Req0_Ready, Req1_Ready}, Rsp_Valid, AluControl, AluA, AluB, eop, ea, eb);
            end
            cyc();
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                Rsp_Ready = (s == stall);
                Req0_Valid = 1'($urandom_range(0, 1)); Req1_Valid = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if ({Req0_Ready, Req1_Ready, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err, AluControl}
                        !== {3'b001, g, er, (er == '0), ~op_legal(eop), 4'h0}) begin
                    errors++; $display("FAIL rnd_rsp[%0d.%0d]: got rdy %b v%b id%b r%h z%b e%b expected rdy 00 v1 id%b r%h z%b e%b",
                                       t, s, {Req0_Ready, Req1_Ready}, Rsp_Valid, Rsp_Id, Rsp_Result, Rsp_Zero, Rsp_Err,
                                       g, er, (er == '0), ~op_legal(eop));
                end
                cyc();
            end
            Req0_Valid = 1'b0; Req1_Valid = 1'b0;
        end
    endtask

    initial begin
        Rst = 1'b0;
        Req0_Valid = 1'b0; Req1_Valid = 1'b0; Rsp_Ready = 1'b0;
        Req0_Op = '0; Req0_A = '0; Req0_B = '0;
        Req1_Op = '0; Req1_A = '0; Req1_B = '0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: OP_W, 4, ALU operation code width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Req0_Valid  input  1  requester 0 has an operation pending.
REQ-006 Req0_Op/Req0_A/Req0_B  input  OP_W/DATA_W/DATA_W  requester 0 opcode and operands.
REQ-007 Req0_Ready  output  1  request 0 accepted this cycle.
REQ-008 Req1_Valid, Req1_Op, Req1_A, Req1_B, Req1_Ready: same as requester 0, for requester 1.
REQ-009 AluControl/AluA/AluB  output  OP_W/DATA_W/DATA_W  drive the shared combinational ALU.
REQ-010 AluResult/AluZero  input  DATA_W/1  shared ALU result and zero flag, same-cycle.
REQ-011 Rsp_Valid  output  1  response held.
REQ-012 Rsp_Id  output  1  requester that owns the response.
REQ-013 Rsp_Result/Rsp_Zero/Rsp_Err  output  DATA_W/1/1  result, zero flag, illegal-opcode flag.
REQ-014 Rsp_Ready  input  1  consumer accepts response.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; exactly one state active.
REQ-016 IDLE: if any Req*_Valid, grant one, assert its Req*_Ready for exactly that cycle, latch Op/A/B and grant id, go EXEC; else stay IDLE.
REQ-017 Arbitration: round-robin; priority pointer starts at requester 0; after a grant, pointer moves to the other requester.
REQ-018 Both valid in IDLE: grant the pointer's requester; single valid: grant it regardless of pointer.
REQ-019 Req*_Ready is 0 in EXEC and RESP; a requester's payload is sampled only when Valid and Ready are both 1.
REQ-020 EXEC: drive AluControl/AluA/AluB from latched values; at the clock edge capture AluResult and AluZero into response registers; go RESP.
REQ-021 Outside EXEC, AluControl, AluA and AluB are 0.
REQ-022 Legal opcodes: 0x0-0x8 and 0xC; any other opcode gives Rsp_Result=0, Rsp_Zero=1, Rsp_Err=1, with no ALU dependence.
REQ-023 RESP: Rsp_Valid=1; Rsp_Id, Rsp_Result, Rsp_Zero and Rsp_Err stay stable until Rsp_Valid & Rsp_Ready.
REQ-024 On Rsp_Valid & Rsp_Ready, go IDLE next cycle; no new grant in the RESP cycle.
REQ-025 Minimum request-to-request spacing is 3 cycles (IDLE, EXEC, RESP); response latency from acceptance is 2 edges.
REQ-026 Rsp_Ready while Rsp_Valid=0 is ignored; Req*_Valid may drop without effect while not granted.
REQ-027 Result width DATA_W; ALU overflow/truncation is passed through unmodified.

Reset
REQ-028 Rst low asynchronously forces IDLE, pointer=0, Req*_Ready=0, Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_Zero=0, Rsp_Err=0, and ALU drives=0.
REQ-029 Reset in EXEC or RESP discards the in-flight operation; no response is produced after reset release.
REQ-030 First grant is possible on the first rising edge after Rst is released while Valid is high.

Verification
REQ-031 Single op: Req0 Op=0x2, A=5, B=7, Rsp_Ready=1 -> Req0_Ready on cycle 0; Rsp_Valid on cycle 2 with Id=0, Result=12, Zero=0, Err=0.
REQ-032 Contention: both valid continuously, Req0 Op=0x6, A=B=9; Req1 Op=0x0, A=0xF0, B=0x0F -> grants alternate 0,1,0,1; responses are Id0 (Result=0, Zero=1) and Id1 (Result=0, Zero=1).
REQ-033 Backpressure: Rsp_Ready=0 for 5 cycles after Rsp_Valid -> outputs are stable; neither Req*_Ready asserts; IDLE entered the cycle after Ready rises.
REQ-034 Illegal op: Req1 Op=0xF -> Rsp_Err=1, Result=0, Zero=1, Id=1.
REQ-035 Reset mid-op: assert Rst during EXEC -> all outputs 0 immediately; no Rsp_Valid after release until a new request is accepted; pointer back to 0.
